// File: rtl/pipeline_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_pkg
//   Types and constants shared by the hazard unit and its helper blocks.
//     hz_state_e  : hazard FSM state (RUN, MD_BUSY)
//     REG_ZERO    : architectural x0, which never carries a real dependency
//     src_hazard(): one operand's RAW match against a destination register
// ----------------------------------------------------------------------------
package pipeline_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A source operand depends on rd only if the operand is actually read
    // and rd is a real register (writes to x0 are discarded).
    function automatic logic src_hazard(input logic       used,
                                        input logic [4:0] rs,
                                        input logic [4:0] rd);
        return used && (rs == rd) && (rd != REG_ZERO);
    endfunction

endpackage

// File: rtl/hazard_md_timer.sv
// ----------------------------------------------------------------------------
// hazard_md_timer
//   Counts cycles spent waiting on a multi-cycle EX operation and flags
//   when the wait reaches MAX_CYCLES.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     cnt_en    : the current cycle is a busy cycle
//     clear     : restart the count (held while no operation is pending)
//     limitHit  : this busy cycle is number MAX_CYCLES (first busy cycle = 1)
// ----------------------------------------------------------------------------
module hazard_md_timer #(
    parameter int MAX_CYCLES = 34
) (
    input  logic clk,
    input  logic rst,
    input  logic cnt_en,
    input  logic clear,
    output logic limitHit
);
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT     = CW'(MAX_CYCLES);
    localparam logic [CW-1:0] LIMIT_M1  = CW'(MAX_CYCLES - 1);

    // cnt_q holds the number of busy cycles already completed, so the
    // current busy cycle is number cnt_q + 1.
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_en && (cnt_q < LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign limitHit = cnt_en && (cnt_q >= LIMIT_M1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// ----------------------------------------------------------------------------
// hazard_unit
//   Pipeline hazard control: load-use interlock, taken-branch flush and
//   stall-until-done handling of multi-cycle mul/div in EX with a watchdog.
//   Ports:
//     clk, rst                    : clock, synchronous active-high reset
//     rs1_id, rs2_id              : ID-stage source registers
//     rs1UsedId, rs2UsedId        : ID instruction really reads rs1 / rs2
//     rd_ex, memReadEx            : EX destination, EX is a load
//     branchTakenEx               : EX redirects the front end
//     mdStartEx, mdDoneEx         : multi-cycle op in EX / its result ready
//     stallPc, stallIfId, stallIdEx : hold the named register
//     flushIfId, flushIdEx        : replace the named register with a NOP
//     bubbleExMem                 : inject a NOP into EX/MEM
//     mdTimeout                   : sticky watchdog error
//     stallCycles                 : saturating count of cycles with stallPc
// ----------------------------------------------------------------------------
module hazard_unit
    import pipeline_pkg::*;
#(
    parameter int MD_MAX_CYCLES = 34,
    parameter int STALL_CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             rs1_id,
    input  logic [4:0]             rs2_id,
    input  logic                   rs1UsedId,
    input  logic                   rs2UsedId,
    input  logic [4:0]             rd_ex,
    input  logic                   memReadEx,
    input  logic                   branchTakenEx,
    input  logic                   mdStartEx,
    input  logic                   mdDoneEx,
    output logic                   stallPc,
    output logic                   stallIfId,
    output logic                   stallIdEx,
    output logic                   flushIfId,
    output logic                   flushIdEx,
    output logic                   bubbleExMem,
    output logic                   mdTimeout,
    output logic [STALL_CNT_W-1:0] stallCycles
);

    hz_state_e              state_q, state_d;
    logic                   md_timeout_q, md_timeout_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   load_use;
    logic                   limit_hit;

    hazard_md_timer #(
        .MAX_CYCLES (MD_MAX_CYCLES)
    ) u_md_timer (
        .clk      (clk),
        .rst      (rst),
        .cnt_en   (state_q == MD_BUSY),
        .clear    (state_q == RUN),
        .limitHit (limit_hit)
    );

    assign load_use = memReadEx &&
                      (src_hazard(rs1UsedId, rs1_id, rd_ex) ||
                       src_hazard(rs2UsedId, rs2_id, rd_ex));

    always_comb begin
        state_d      = state_q;
        md_timeout_d = md_timeout_q;
        stallPc      = 1'b0;
        stallIfId    = 1'b0;
        stallIdEx    = 1'b0;
        flushIfId    = 1'b0;
        flushIdEx    = 1'b0;
        bubbleExMem  = 1'b0;

        unique case (state_q)
            RUN: begin
                if (branchTakenEx) begin
                    // Wrong-path instructions in IF/ID and ID/EX are killed;
                    // any interlock they would have caused is moot.
                    flushIfId = 1'b1;
                    flushIdEx = 1'b1;
                end else if (mdStartEx && !mdDoneEx) begin
                    stallPc     = 1'b1;
                    stallIfId   = 1'b1;
                    stallIdEx   = 1'b1;
                    bubbleExMem = 1'b1;
                    state_d     = MD_BUSY;
                end else if (load_use) begin
                    // Hold the consumer in ID and send a bubble into EX.
                    stallPc   = 1'b1;
                    stallIfId = 1'b1;
                    flushIdEx = 1'b1;
                end
            end
            MD_BUSY: begin
                if (mdDoneEx) begin
                    state_d = RUN;
                end else if (limit_hit) begin
                    // Give up on the op: release the pipeline and record it.
                    state_d      = RUN;
                    md_timeout_d = 1'b1;
                end else begin
                    stallPc     = 1'b1;
                    stallIfId   = 1'b1;
                    stallIdEx   = 1'b1;
                    bubbleExMem = 1'b1;
                end
            end
        endcase

        // Reset can arrive in either state; no control output may leak out.
        if (rst) begin
            stallPc     = 1'b0;
            stallIfId   = 1'b0;
            stallIdEx   = 1'b0;
            flushIfId   = 1'b0;
            flushIdEx   = 1'b0;
            bubbleExMem = 1'b0;
        end

        stall_cnt_d = stall_cnt_q;
        if (stallPc && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            md_timeout_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            md_timeout_q <= md_timeout_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign mdTimeout   = md_timeout_q;
    assign stallCycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// ----------------------------------------------------------------------------
// tb_hazard_unit
//   Directed scenarios with literal expectations followed by randomized
//   traffic, all compared every cycle against a behavioural model.
//   Output vector order: {stallPc, stallIfId, stallIdEx, flushIfId,
//   flushIdEx, bubbleExMem}.
// ----------------------------------------------------------------------------
module tb_hazard_unit;

    localparam int MDMAX = 8;
    localparam int SW    = 5;
    localparam int SMAX  = (1 << SW) - 1;

    localparam logic [5:0] O_NONE = 6'b000000;
    localparam logic [5:0] O_LU   = 6'b110010;
    localparam logic [5:0] O_BR   = 6'b000110;
    localparam logic [5:0] O_MD   = 6'b111001;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    rs1_id = '0, rs2_id = '0, rd_ex = '0;
    logic          rs1UsedId = 1'b0, rs2UsedId = 1'b0;
    logic          memReadEx = 1'b0, branchTakenEx = 1'b0;
    logic          mdStartEx = 1'b0, mdDoneEx = 1'b0;
    logic          stallPc, stallIfId, stallIdEx;
    logic          flushIfId, flushIdEx, bubbleExMem;
    logic          mdTimeout;
    logic [SW-1:0] stallCycles;

    always #5 clk = ~clk;

    hazard_unit #(
        .MD_MAX_CYCLES (MDMAX),
        .STALL_CNT_W   (SW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rs1_id        (rs1_id),
        .rs2_id        (rs2_id),
        .rs1UsedId     (rs1UsedId),
        .rs2UsedId     (rs2UsedId),
        .rd_ex         (rd_ex),
        .memReadEx     (memReadEx),
        .branchTakenEx (branchTakenEx),
        .mdStartEx     (mdStartEx),
        .mdDoneEx      (mdDoneEx),
        .stallPc       (stallPc),
        .stallIfId     (stallIfId),
        .stallIdEx     (stallIdEx),
        .flushIfId     (flushIfId),
        .flushIdEx     (flushIdEx),
        .bubbleExMem   (bubbleExMem),
        .mdTimeout     (mdTimeout),
        .stallCycles   (stallCycles)
    );

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_busy    = 1'b0;   // an op is pending after its start cycle
    int m_n       = 0;      // number of the current busy cycle (1-based)
    bit m_to      = 1'b0;
    int m_stalls  = 0;

    function automatic logic [5:0] model_outs(input bit r, input bit busy, input int n,
                                              input bit br, input bit st, input bit dn,
                                              input bit lu);
        if (r) return O_NONE;
        if (!busy) begin
            if (br)        return O_BR;
            if (st && !dn) return O_MD;
            if (lu)        return O_LU;
            return O_NONE;
        end
        if (!dn && n < MDMAX) return O_MD;
        return O_NONE;
    endfunction

    logic       lu_exp;
    logic [5:0] exp_o;
    logic [5:0] act_o;

    assign lu_exp = memReadEx && (rd_ex != 5'd0) &&
                    ((rs1UsedId && rs1_id == rd_ex) || (rs2UsedId && rs2_id == rd_ex));
    assign exp_o  = model_outs(rst, m_busy, m_n, branchTakenEx, mdStartEx, mdDoneEx, lu_exp);
    assign act_o  = {stallPc, stallIfId, stallIdEx, flushIfId, flushIdEx, bubbleExMem};

    always @(posedge clk) begin
        if (rst) begin
            m_busy   <= 1'b0;
            m_n      <= 0;
            m_to     <= 1'b0;
            m_stalls <= 0;
        end else begin
            if (exp_o[5] && m_stalls < SMAX) m_stalls <= m_stalls + 1;
            if (!m_busy) begin
                if (!branchTakenEx && mdStartEx && !mdDoneEx) begin
                    m_busy <= 1'b1;
                    m_n    <= 1;
                end
            end else if (mdDoneEx) begin
                m_busy <= 1'b0;
            end else if (m_n >= MDMAX) begin
                m_busy <= 1'b0;
                m_to   <= 1'b1;
            end else begin
                m_n <= m_n + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("outs", int'(act_o), int'(exp_o));
            check("mdTimeout", int'(mdTimeout), int'(m_to));
            check("stallCycles", int'(stallCycles), m_stalls);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1_id = '0; rs2_id = '0; rd_ex = '0;
        rs1UsedId = 1'b0; rs2UsedId = 1'b0;
        memReadEx = 1'b0; branchTakenEx = 1'b0;
        mdStartEx = 1'b0; mdDoneEx = 1'b0;
    endtask

    task automatic peek(input string nm, input logic [5:0] eo, input int esc, input bit eto);
        @(negedge clk);
        #1;
        check({nm, ".outs"}, int'(act_o), int'(eo));
        check({nm, ".stallCycles"}, int'(stallCycles), esc);
        check({nm, ".mdTimeout"}, int'(mdTimeout), int'(eto));
    endtask

    task automatic set_load_use();
        memReadEx = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; rs1UsedId = 1'b1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        started = 1'b1;
        peek("reset", O_NONE, 0, 1'b0);
        step();
        rst = 1'b0;

        // load-use on rs1
        set_load_use();
        peek("load_use", O_LU, 0, 1'b0);
        step();

        // x0 destination is never a hazard
        idle();
        memReadEx = 1'b1; rd_ex = 5'd0; rs1_id = 5'd0; rs1UsedId = 1'b1;
        peek("x0", O_NONE, 1, 1'b0);
        step();

        // matching but unused rs2 is not a hazard
        idle();
        memReadEx = 1'b1; rd_ex = 5'd7; rs2_id = 5'd7; rs2UsedId = 1'b0;
        peek("unused_rs2", O_NONE, 1, 1'b0);
        step();

        // taken branch overrides load-use
        idle();
        set_load_use();
        branchTakenEx = 1'b1;
        peek("branch", O_BR, 1, 1'b0);
        step();
        idle();
        peek("after_branch", O_NONE, 1, 1'b0);
        step();

        // fresh counters for the multi-cycle scenario
        rst = 1'b1;
        step();
        rst = 1'b0;

        // MD op finishing on the 4th cycle after start
        mdStartEx = 1'b1; mdDoneEx = 1'b0;
        for (int k = 0; k < 4; k++) begin
            peek("md_wait", O_MD, k, 1'b0);
            step();
        end
        mdDoneEx = 1'b1;
        peek("md_done", O_NONE, 4, 1'b0);
        step();
        idle();
        peek("md_after", O_NONE, 4, 1'b0);
        step();

        // watchdog: done never comes
        mdStartEx = 1'b1; mdDoneEx = 1'b0;
        for (int k = 0; k < MDMAX; k++) begin
            peek("wd_wait", O_MD, 4 + k, 1'b0);
            step();
        end
        peek("wd_limit", O_NONE, 4 + MDMAX, 1'b0);
        step();
        idle();
        set_load_use();
        peek("wd_run", O_LU, 4 + MDMAX, 1'b1);
        step();
        idle();
        for (int k = 0; k < 20; k++) step();
        peek("wd_sticky", O_NONE, 5 + MDMAX, 1'b1);
        step();

        // reset on the 3rd busy cycle
        mdStartEx = 1'b1; mdDoneEx = 1'b0;
        for (int k = 0; k < 3; k++) step();
        rst = 1'b1;
        peek("rst_mid", O_NONE, 8 + MDMAX, 1'b1);
        step();
        rst = 1'b0;
        idle();
        peek("rst_release", O_NONE, 0, 1'b0);
        step();
        peek("rst_quiet", O_NONE, 0, 1'b0);
        step();

        // stall counter saturates
        set_load_use();
        for (int k = 0; k < SMAX + 4; k++) step();
        idle();
        peek("saturate", O_NONE, SMAX, 1'b0);
        step();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            rs1_id    = 5'($urandom_range(0, 3));
            rs2_id    = 5'($urandom_range(0, 3));
            rd_ex     = 5'($urandom_range(0, 3));
            rs1UsedId = 1'($urandom_range(0, 1));
            rs2UsedId = 1'($urandom_range(0, 1));
            memReadEx = 1'($urandom_range(0, 1));
            branchTakenEx = ($urandom_range(0, 7) == 0);
            if (m_busy) begin
                mdStartEx = 1'b1;
                mdDoneEx  = ($urandom_range(0, 5) == 0);
            end else begin
                mdStartEx = ($urandom_range(0, 7) == 0);
                mdDoneEx  = mdStartEx && ($urandom_range(0, 3) == 0);
                if (mdStartEx) begin
                    branchTakenEx = 1'b0;
                    memReadEx     = 1'b0;
                end
            end
            step();
        end

        rst = 1'b0;
        idle();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter: MD_MAX_CYCLES, default 34, EX multi-cycle op watchdog limit in cycles.
REQ-002 SHALL have parameter: STALL_CNT_W, default 16, width of the stall-cycle counter.
REQ-003 SHALL have port: clk  in  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port: rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have ports: rs1_id, rs2_id  in  5 each  source registers of the instruction in ID.
REQ-006 SHALL have ports: rs1UsedId, rs2UsedId  in  1 each  ID instruction actually reads rs1/rs2.
REQ-007 SHALL have port: rd_ex  in  5  destination register of the instruction in EX.
REQ-008 SHALL have port: memReadEx  in  1  EX instruction is a load.
REQ-009 SHALL have port: branchTakenEx  in  1  EX branch/jump resolved as redirect.
REQ-010 SHALL have ports: mdStartEx, mdDoneEx  in  1 each  multi-cycle mul/div occupies EX / result ready.
REQ-011 SHALL have ports: stallPc, stallIfId, stallIdEx  out  1 each  hold the PC / IF-ID / ID-EX register.
REQ-012 SHALL have ports: flushIfId, flushIdEx, bubbleExMem  out  1 each  insert a NOP into the named register.
REQ-013 SHALL have port: mdTimeout  out  1  sticky watchdog error flag.
REQ-014 SHALL have port: stallCycles  out  STALL_CNT_W  saturating count of cycles with stallPc=1.

Function
REQ-015 SHALL implement a two-state FSM, RUN and MD_BUSY, in which all control outputs are combinational from the current state and inputs.
REQ-016 SHALL raise loadUse in RUN when memReadEx=1, rd_ex!=0, and either (rs1UsedId and rs1_id==rd_ex) or (rs2UsedId and rs2_id==rd_ex).
REQ-017 SHALL, on loadUse, assert stallPc=1, stallIfId=1, and flushIdEx=1 for exactly that cycle, inserting one bubble; no state change occurs.
REQ-018 SHALL, when branchTakenEx=1, assert flushIfId=1 and flushIdEx=1, force all stall outputs to 0, and override loadUse.
REQ-019 SHALL, in RUN with mdStartEx=1 and mdDoneEx=0, assert stallPc, stallIfId, stallIdEx, and bubbleExMem in that same cycle and transition to MD_BUSY.
REQ-020 SHALL treat RUN with mdStartEx=1 and mdDoneEx=1 as a zero-wait op: no stall and no transition.
REQ-021 SHALL hold stallPc, stallIfId, stallIdEx, and bubbleExMem at 1 in MD_BUSY; loadUse and branchTakenEx are ignored there.
REQ-022 SHALL, in MD_BUSY with mdDoneEx=1, deassert all outputs that cycle so the result advances, and return to RUN.
REQ-023 SHALL increment a busy counter on every cycle spent in MD_BUSY, starting at 1 on the first MD_BUSY cycle.
REQ-024 SHALL, if the busy counter reaches MD_MAX_CYCLES without mdDoneEx, set mdTimeout=1, deassert stalls that cycle, and return to RUN.
REQ-025 SHALL keep mdTimeout at 1 until reset.
REQ-026 SHALL increment stallCycles on every cycle with stallPc=1 and saturate at all-ones with no wrap.
REQ-027 SHALL ensure that stallX and flushX for the same register are never both 1 in the same cycle.
REQ-028 SHALL treat a match on register x0 as no hazard.

Reset
REQ-029 SHALL, while rst=1, force the state to RUN, the busy counter to 0, stallCycles to 0, and mdTimeout to 0.
REQ-030 SHALL drive all stall, flush, and bubble outputs to 0 during reset, including reset asserted in MD_BUSY.
REQ-031 SHALL resume from RUN with no residual stall on the first cycle after rst falls.

Structure
REQ-032 SHALL declare the FSM state enum (RUN, MD_BUSY) and the constant REG_ZERO=5'd0 in the shared package pipeline_pkg.
REQ-033 SHALL place the busy counter and watchdog compare in one sub-module, hazard_md_timer (inputs clk, rst, count-enable, clear; output limitHit).
REQ-034 SHALL keep the loadUse comparator and output decode in hazard_unit.

Verification
REQ-035 SHALL cover load-use: memReadEx=1, rd_ex=5, rs1_id=5, rs1UsedId=1 -> one cycle of stallPc=stallIfId=flushIdEx=1; stallCycles=1.
REQ-036 SHALL cover x0 and unused operands: rd_ex=0 with rs1_id=0, then rd_ex=7 with rs2_id=7 and rs2UsedId=0 -> no stall in either case.
REQ-037 SHALL cover branch over load-use: loadUse conditions true and branchTakenEx=1 -> flushIfId=flushIdEx=1, stallPc=0, stallCycles unchanged.
REQ-038 SHALL cover MD op: mdStartEx=1 with mdDoneEx asserted 4 cycles later -> stalls and bubbleExMem high for 4 cycles, low on the done cycle, stallCycles=4.
REQ-039 SHALL cover watchdog: MD_MAX_CYCLES=8 with mdDoneEx never asserted -> mdTimeout=1 after the 8th busy cycle, state RUN, flag still 1 at 20 cycles later.
REQ-040 SHALL cover reset mid-op: rst pulsed on the 3rd MD_BUSY cycle -> all outputs 0, stallCycles=0, mdTimeout=0, no stall after release.
